i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DATA_W, default 16, sample width in bits; legal range 8..31.
REQ-002 i_clk  input  1  audio clock, 6 MHz.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_left  input  DATA_W  left sample, signed two's complement.
REQ-005 i_right  input  DATA_W  right sample, signed two's complement.
REQ-006 i_valid  input  1  sample pair offered.
REQ-007 o_ready  output  1  holding register empty; pair accepted when i_valid && o_ready.
REQ-008 o_bclk  output  1  I2S bit clock, i_clk/2 (3 MHz).
REQ-009 o_lrclk  output  1  I2S word select; 0 = left, 1 = right.
REQ-010 o_sdata  output  1  I2S serial data, MSB first.
REQ-011 o_frame  output  1  one-cycle pulse at frame start.
REQ-012 o_underrun  output  1  one-cycle pulse when a frame starts with no sample available.

Function
REQ-013 7-bit frame counter cnt SHALL increment every i_clk cycle and wrap 127->0, giving a 128-cycle frame (46.875 kHz).
REQ-014 Slot index s = cnt[6:1] (0..63); each slot is one bclk period.
REQ-015 o_bclk SHALL equal cnt[0], registered: low on even cnt, high on odd cnt; o_sdata and o_lrclk SHALL change only on the bclk falling edge.
REQ-016 o_lrclk SHALL be s[5]: 0 for s 0..31, 1 for s 32..63.
REQ-017 o_sdata SHALL carry left bit DATA_W-s during s = 1..DATA_W and right bit DATA_W-(s-32) during s = 33..32+DATA_W; it SHALL be 0 in all other slots (standard I2S: one-bclk delay after the lrclk edge, zero padding).
REQ-018 The holding register SHALL capture {i_left,i_right} on i_valid && o_ready; o_ready is registered and SHALL go 0 the cycle after an accept.
REQ-019 On the cnt 127->0 edge, the holding register SHALL be loaded into the shift register and marked empty; o_ready SHALL return to 1 the following cycle.
REQ-020 If an accept occurs in the cnt==127 cycle while holding is empty, the accepted pair SHALL bypass directly into the shift register for the new frame, holding SHALL stay empty, and no underrun is flagged.
REQ-021 If holding is empty at cnt 127->0 with no bypass, the shift register SHALL load zero (silence) and o_underrun SHALL pulse during cnt==0.
REQ-022 o_frame SHALL pulse during cnt==0 of every frame.
REQ-023 i_valid while o_ready==0 SHALL be ignored; inputs are not sampled.
REQ-024 Latency: a pair accepted in frame N appears on o_sdata in frame N+1 (or in frame N+1 via bypass if accepted at cnt==127 of frame N).

Reset
REQ-025 While i_rst_n==0: cnt=0, holding empty, shift register=0, o_ready=0, o_bclk=0, o_lrclk=0, o_sdata=0, o_frame=0, o_underrun=0.
REQ-026 Reset deassertion mid-frame SHALL restart at cnt=0; the first frame after reset SHALL be silent and SHALL assert o_underrun unless a REQ-020 bypass occurs.
REQ-027 o_ready SHALL go to 1 on the first clock edge after reset release.

Structure
REQ-028 Package aud_pkg SHALL hold FRAME_CLKS=128, SLOT_BITS=32, and a sample-pair struct typedef.
REQ-029 Single module; no sub-module required. The frame counter, holding register and shift register stay inline.

Verification
REQ-030 Frame and clock timing: L=16'hA5C3, R=16'h0001 offered continuously -> o_bclk period 2 cycles, o_lrclk period 128 cycles, slots 1..16 = A5C3 MSB first, slots 33..48 = 0001, all other slots 0.
REQ-031 Underrun: no i_valid after reset -> o_sdata=0 throughout and o_underrun pulses at each cnt==0; a single pair then yields exactly one non-silent frame followed by underruns.
REQ-032 Bypass: holding empty, pair 16'h7FFF/16'h8000 accepted at cnt==127 -> transmitted in the next frame, no o_underrun, o_ready stays 1.
REQ-033 Backpressure: i_valid held high with changing data -> exactly one pair accepted per frame, and each accepted pair is transmitted intact and in order.
REQ-034 Mid-frame reset: assert i_rst_n=0 at cnt==70 -> all outputs 0 asynchronously; after release, cnt restarts at 0 and o_frame pulses on the first cycle.
REQ-035 DATA_W=24: L=24'h800001 -> slots 1..24 carry 800001 and slots 25..31 are 0.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared audio constants, the stereo sample-pair type and the slot-to-bit mapping
// used by the I2S transmitter.
package aud_pkg;

  localparam int unsigned FRAME_CLKS = 128;
  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned CNT_W      = 7;

  typedef struct packed {
    logic [SLOT_BITS-1:0] left;
    logic [SLOT_BITS-1:0] right;
  } pair_t;

  // Serial bit for a slot: one-slot delay after the word-select edge, MSB first, zero padded.
  function automatic logic slot_bit(input pair_t p, input logic [5:0] slot, input int unsigned w);
    int unsigned k;
    logic [4:0]  idx;
    logic        b;
    k = {27'd0, slot[4:0]};
    b = 1'b0;
    if (k >= 1 && k <= w) begin
      idx = 5'(w - k);
      b   = slot[5] ? p.right[idx] : p.left[idx];
    end
    return b;
  endfunction

endpackage

// File: rtl/i2s_tx.sv
// I2S transmitter: 128-clock frame, 64 bclk slots, single holding register with
// frame-boundary bypass and silence on underrun.
module i2s_tx
  import aud_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_bclk,
  output logic              o_lrclk,
  output logic              o_sdata,
  output logic              o_frame,
  output logic              o_underrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLKS - 1);
  localparam int unsigned      PAD_W    = SLOT_BITS - DATA_W;

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_full;
  pair_t            r_hold;
  pair_t            r_shift;
  logic             r_ready;
  logic             r_bclk;
  logic             r_lrclk;
  logic             r_sdata;
  logic             r_frame;
  logic             r_underrun;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_edge;
  logic             w_acc;
  pair_t            w_in;
  pair_t            w_hold_nxt;
  pair_t            w_shift_nxt;
  logic             w_full_nxt;
  logic             w_underrun_nxt;

  // The first edge after reset release acts as a frame boundary so cnt==0 is a full cycle.
  always_comb begin
    w_edge         = !r_run || (r_cnt == CNT_LAST);
    w_acc          = i_valid && r_ready;
    w_cnt_nxt      = r_run ? r_cnt + 7'd1 : '0;
    w_in.left      = {{PAD_W{1'b0}}, i_left};
    w_in.right     = {{PAD_W{1'b0}}, i_right};
    w_hold_nxt     = r_hold;
    w_shift_nxt    = r_shift;
    w_full_nxt     = r_full;
    w_underrun_nxt = 1'b0;
    if (w_edge) begin
      w_full_nxt = 1'b0;
      if (r_full) begin
        w_shift_nxt = r_hold;
      end else if (w_acc) begin
        w_shift_nxt = w_in;
      end else begin
        w_shift_nxt    = '0;
        w_underrun_nxt = 1'b1;
      end
    end else if (w_acc) begin
      w_hold_nxt = w_in;
      w_full_nxt = 1'b1;
    end
  end

  // Outputs are registered from the next count so they line up with cnt in each cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_run      <= 1'b0;
      r_full     <= 1'b0;
      r_hold     <= '0;
      r_shift    <= '0;
      r_ready    <= 1'b0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_sdata    <= 1'b0;
      r_frame    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_run      <= 1'b1;
      r_full     <= w_full_nxt;
      r_hold     <= w_hold_nxt;
      r_shift    <= w_shift_nxt;
      r_ready    <= !w_full_nxt;
      r_bclk     <= w_cnt_nxt[0];
      r_lrclk    <= w_cnt_nxt[CNT_W-1];
      r_sdata    <= slot_bit(r_shift, w_cnt_nxt[CNT_W-1:1], DATA_W);
      r_frame    <= w_edge;
      r_underrun <= w_underrun_nxt;
    end
  end

  assign o_ready    = r_ready;
  assign o_bclk     = r_bclk;
  assign o_lrclk    = r_lrclk;
  assign o_sdata    = r_sdata;
  assign o_frame    = r_frame;
  assign o_underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: 16-bit and 24-bit instances, frame-by-frame capture
// against hand-chosen sample pairs.
module tb_i2s_tx;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [15:0] l16, r16;
  logic [23:0] l24, r24;
  logic        ready, bclk, lrclk, sdata, frame, underrun;
  logic        ready24, bclk24, lrclk24, sdata24, frame24, underrun24;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        tb_run;
  logic [6:0]  tb_cnt;
  logic [63:0] sd24;

  i2s_tx #(.DATA_W(16)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_left(l16), .i_right(r16), .i_valid(valid),
    .o_ready(ready), .o_bclk(bclk), .o_lrclk(lrclk), .o_sdata(sdata),
    .o_frame(frame), .o_underrun(underrun)
  );

  i2s_tx #(.DATA_W(24)) u_dut24 (
    .i_clk(clk), .i_rst_n(rst_n), .i_left(l24), .i_right(r24), .i_valid(valid),
    .o_ready(ready24), .o_bclk(bclk24), .o_lrclk(lrclk24), .o_sdata(sdata24),
    .o_frame(frame24), .o_underrun(underrun24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame position: first edge after reset enters cnt 0, then counts 0..127.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_run <= 1'b0;
      tb_cnt <= '0;
    end else if (!tb_run) begin
      tb_run <= 1'b1;
    end else begin
      tb_cnt <= tb_cnt + 7'd1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic [31:0] l, input logic [31:0] r,
                                            input int w);
    logic [63:0] v;
    v = '0;
    for (int s = 1; s <= w; s++) begin
      v[s]      = l[w-s];
      v[32 + s] = r[w-s];
    end
    return v;
  endfunction

  // Capture one frame starting at the cnt==0 sample point; drive stimulus after each sample.
  task automatic capture(input string tag, input int offer_at, input logic [15:0] l,
                         input logic [15:0] r, input logic drive, input logic [7:0] seed,
                         input logic under_exp, input int ready0_exp, input logic [63:0] sd_exp);
    logic [63:0] sd;
    logic        prev, fr0, un0;
    logic [6:0]  ic;
    int          n_bclk, n_lr, n_hold, n_stray, n_rdy0;
    sd = '0; prev = 1'b0; fr0 = 1'b0; un0 = 1'b0;
    n_bclk = 0; n_lr = 0; n_hold = 0; n_stray = 0; n_rdy0 = 0;
    for (int i = 0; i < 128; i++) begin
      ic = 7'(i);
      if (ic[0]) begin
        sd[i>>1]   = sdata;
        sd24[i>>1] = sdata24;
        if (sdata !== prev) n_hold++;
      end else begin
        prev = sdata;
      end
      if (bclk !== ic[0]) n_bclk++;
      if (lrclk !== ic[6]) n_lr++;
      if (i == 0) begin
        fr0 = frame;
        un0 = underrun;
      end else if (frame || underrun) begin
        n_stray++;
      end
      if (!ready) n_rdy0++;
      if (drive) begin
        valid = 1'b1;
        l16   = {seed, 1'b0, ic};
        r16   = ~{seed, 1'b0, ic};
      end else begin
        valid = (i == offer_at);
        if (i == offer_at) begin
          l16 = l;
          r16 = r;
        end
      end
      @(negedge clk);
    end
    check({tag, " sdata"}, sd, sd_exp);
    check({tag, " frame@0"}, {63'd0, fr0}, 64'd1);
    check({tag, " underrun@0"}, {63'd0, un0}, {63'd0, under_exp});
    check({tag, " stray pulses"}, 64'(n_stray), 64'd0);
    check({tag, " bclk errs"}, 64'(n_bclk), 64'd0);
    check({tag, " lrclk errs"}, 64'(n_lr), 64'd0);
    check({tag, " sdata on rise"}, 64'(n_hold), 64'd0);
    check({tag, " ready low cycles"}, 64'(n_rdy0), 64'(ready0_exp));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; valid = 1'b0;
    l16 = '0; r16 = '0;
    l24 = 24'h800001; r24 = 24'h123456;
    sd24 = '0;
    repeat (3) @(negedge clk);
    check("reset outs16", {58'd0, ready, bclk, lrclk, sdata, frame, underrun}, 64'd0);
    check("reset outs24", {58'd0, ready24, bclk24, lrclk24, sdata24, frame24, underrun24}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after release", {63'd0, ready}, 64'd1);

    capture("F0 idle", -1, 16'h0, 16'h0, 1'b0, 8'h0, 1'b1, 0, 64'd0);
    capture("F1 offer", 10, 16'hA5C3, 16'h0001, 1'b0, 8'h0, 1'b1, 117, 64'd0);
    capture("F2 A5C3", -1, 16'h0, 16'h0, 1'b0, 8'h0, 1'b0, 0,
            exp_frame(32'h0000A5C3, 32'h00000001, 16));
    check("F2 w24 sdata", sd24, exp_frame(32'h00800001, 32'h00123456, 24));
    check("F2 w24 pad 25..31", {57'd0, sd24[31:25]}, 64'd0);
    check("F2 w24 msb slot1", {63'd0, sd24[1]}, 64'd1);
    capture("F3 bypass", 127, 16'h7FFF, 16'h8000, 1'b0, 8'h0, 1'b1, 0, 64'd0);
    capture("F4 7FFF", -1, 16'h0, 16'h0, 1'b0, 8'h0, 1'b0, 0,
            exp_frame(32'h00007FFF, 32'h00008000, 16));
    capture("F5 bp", -1, 16'h0, 16'h0, 1'b1, 8'h31, 1'b1, 127, 64'd0);
    capture("F6 bp", -1, 16'h0, 16'h0, 1'b1, 8'h52, 1'b0, 127,
            exp_frame(32'h00003100, 32'h0000CEFF, 16));
    capture("F7 bp", -1, 16'h0, 16'h0, 1'b1, 8'h9E, 1'b0, 127,
            exp_frame(32'h00005200, 32'h0000ADFF, 16));
    capture("F8 drain", -1, 16'h0, 16'h0, 1'b0, 8'h0, 1'b0, 0,
            exp_frame(32'h00009E00, 32'h000061FF, 16));

    n = 0;
    while (tb_cnt != 7'd70 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reach cnt70", {63'd0, n < 300}, 64'd1);
    check("pre-reset lrclk/ready", {62'd0, lrclk, ready}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outs16", {58'd0, ready, bclk, lrclk, sdata, frame, underrun}, 64'd0);
    check("async reset outs24", {58'd0, ready24, bclk24, lrclk24, sdata24, frame24, underrun24},
          64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    capture("R0 restart", -1, 16'h0, 16'h0, 1'b0, 8'h0, 1'b1, 0, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
